// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a bank of common-anode
// 7-segment digits that share one segmentos_7 decoder.
//
// Each digit slot is DEAD_CYCLES blanked cycles followed by PRESCALE lit cycles.
// Displayed codes are double-buffered: a load parks data_in in a shadow register,
// and it is copied to the active register at frame wrap, or at once while idle.
//
// Optional feature (compile-time macro SEG7_LEADING_ZERO_BLANK_EN):
//   when defined, digit i (i > 0) stays dark in its ON slot if every active code
//   from digit i up to the top digit is 8'h00.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   enable         scan enable; low forces idle
//   data_in        packed digit codes, digit 0 in bits [7:0]
//   load_valid     update request for data_in
//   load_ready     shadow buffer free
//   digit_code_out code of the current digit, to the decoder input
//   anode_n        active-low digit enables
//   digit_idx      index of the current digit slot
//   frame_tick     one-cycle pulse on the last lit cycle of the top digit
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned DEAD_CYCLES = 16,
    parameter int unsigned IDX_W       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [8*NUM_DIGITS-1:0] data_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [7:0]              digit_code_out,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DEAD = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;

    // With no dead time the slot sequence goes straight from ON to ON.
    localparam logic [1:0] ST_SLOT_START = (DEAD_CYCLES == 0) ? ST_ON : ST_DEAD;

    localparam int unsigned CNT_MAX   = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned ON_LAST   = PRESCALE - 1;
    localparam int unsigned DEAD_LAST = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [8*NUM_DIGITS-1:0] active_q, shadow_q;
    logic                    pending_q;
    logic                    wrap;
    logic                    accept;
    logic                    commit;
    logic                    blank;

    // Slot sequencing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SLOT_START;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_DEAD: begin
                    if (cnt_q == CNT_W'(DEAD_LAST)) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (cnt_q == CNT_W'(ON_LAST)) begin
                        state_d = ST_SLOT_START;
                        cnt_d   = '0;
                        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Double buffer. Accept needs pending=0 and commit needs pending=1, so they
    // never coincide.
    assign load_ready = !pending_q;
    assign accept     = load_valid && load_ready;
    assign commit     = pending_q && (wrap || (state_q == ST_IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else if (accept) begin
            shadow_q  <= data_in;
            pending_q <= 1'b1;
        end else if (commit) begin
            active_q  <= shadow_q;
            pending_q <= 1'b0;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // zero_tail[i] is set when digits i..NUM_DIGITS-1 all hold 8'h00.
    logic [NUM_DIGITS-1:0] zero_tail;

    always_comb begin
        zero_tail = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (active_q[j*8 +: 8] != 8'h00) begin
                    zero_tail[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        blank = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                blank = zero_tail[i];
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Outputs.
    always_comb begin
        digit_code_out = 8'h00;
        anode_n        = '1;
        if (state_q != ST_IDLE) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    digit_code_out = active_q[i*8 +: 8];
                end
            end
        end
        if (state_q == ST_ON && !blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                anode_n[i] = (idx_q != IDX_W'(i));
            end
        end
    end

    assign digit_idx  = idx_q;
    assign frame_tick = wrap;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, PRESCALE=4, DEAD_CYCLES=2).
// A timeline model (cycles since scan start, modulo the frame length) predicts
// every output each cycle; directed steps add hand-computed literal checks.
module tb_seg7_scan_ctrl;

    localparam int NUM   = 4;
    localparam int PRE   = 4;
    localparam int DEAD  = 2;
    localparam int SLOT  = PRE + DEAD;
    localparam int FRAME = NUM * SLOT;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [31:0]   data_in;
    logic          load_valid;
    logic          load_ready;
    logic [7:0]    digit_code_out;
    logic [3:0]    anode_n;
    logic [1:0]    digit_idx;
    logic          frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS (NUM),
        .PRESCALE   (PRE),
        .DEAD_CYCLES(DEAD),
        .IDX_W      (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .data_in       (data_in),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .digit_code_out(digit_code_out),
        .anode_n       (anode_n),
        .digit_idx     (digit_idx),
        .frame_tick    (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    logic        m_run;        // scanning (not idle)
    int          m_t;          // cycles since first dead cycle, modulo FRAME
    logic        m_pending;
    logic [31:0] m_shadow;
    logic [7:0]  m_active [NUM];
    logic        m_tick;
    logic        m_commit;

    assign m_tick   = m_run && enable && (m_t == FRAME - 1);
    assign m_commit = m_pending && (m_tick || !m_run);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run     <= 1'b0;
            m_t       <= 0;
            m_pending <= 1'b0;
            m_shadow  <= '0;
            for (int j = 0; j < NUM; j++) m_active[j] <= 8'h00;
        end else begin
            if (load_valid && !m_pending) begin
                m_shadow  <= data_in;
                m_pending <= 1'b1;
            end else if (m_commit) begin
                for (int j = 0; j < NUM; j++) m_active[j] <= m_shadow[j*8 +: 8];
                m_pending <= 1'b0;
            end
            if (!enable) begin
                m_run <= 1'b0;
            end else if (!m_run) begin
                m_run <= 1'b1;
                m_t   <= 0;
            end else begin
                m_t <= (m_t + 1) % FRAME;
            end
        end
    end

    // Per-cycle comparison, 3 time units after each rising edge.
    int         c_slot;
    logic [3:0] c_anode;
    logic [7:0] c_code;
    logic       c_blank;
    logic [3:0] c_one;

    always begin
        @(posedge clk);
        #3;
        if (rst_n) begin
            c_one   = 4'b0001;
            c_anode = 4'b1111;
            c_code  = 8'h00;
            c_slot  = 0;
            if (m_run) begin
                c_slot  = m_t / SLOT;
                c_code  = m_active[c_slot];
                c_blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (c_slot != 0) begin
                    c_blank = 1'b1;
                    for (int j = c_slot; j < NUM; j++)
                        if (m_active[j] != 8'h00) c_blank = 1'b0;
                end
`endif
                if ((m_t % SLOT) >= DEAD && !c_blank) c_anode = ~(c_one << c_slot);
            end
            check("model_anode", anode_n, c_anode);
            check("model_code", digit_code_out, c_code);
            check("model_idx", digit_idx, c_slot);
            check("model_tick", frame_tick, m_tick);
            check("model_ready", load_ready, !m_pending);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_lit(input int i, input logic [7:0] code);
        logic [3:0] one;
        logic [3:0] want;
        int n;
        one  = 4'b0001;
        want = ~(one << i);
        n    = 0;
        while (anode_n !== want && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("lit_anode", anode_n, want);
        check("lit_code", digit_code_out, code);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", frame_tick, 1'b1);
    endtask

    task automatic load(input logic [31:0] d);
        data_in    = d;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    int n;
    int lit;

    initial begin
        rst_n      = 1'b1;
        enable     = 1'b0;
        data_in    = '0;
        load_valid = 1'b0;

        // Asynchronous reset mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        check("rst_anode", anode_n, 4'b1111);
        check("rst_code", digit_code_out, 8'h00);
        check("rst_ready", load_ready, 1'b1);
        check("rst_idx", digit_idx, 2'd0);
        check("rst_tick", frame_tick, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_anode", anode_n, 4'b1111);
        check("idle_code", digit_code_out, 8'h00);

        // Load while idle: commits one cycle after accept.
        load(32'h09050100);
        check("idle_load_busy", load_ready, 1'b0);
        @(negedge clk);
        check("idle_load_free", load_ready, 1'b1);
        enable = 1'b1;
        @(negedge clk);
        check("dead0_anode", anode_n, 4'b1111);
        @(negedge clk);
        check("dead1_anode", anode_n, 4'b1111);
        @(negedge clk);
        check("first_lit_anode", anode_n, 4'b1110);
        check("first_lit_code", digit_code_out, 8'h00);
        wait_lit(1, 8'h01);
        wait_lit(2, 8'h05);
        wait_lit(3, 8'h09);
        wait_tick();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 100);
        check("frame_len", n, FRAME);

        // Mid-frame update takes effect at the next frame.
        wait_lit(1, 8'h01);
        load(32'h01020304);
        check("mid_busy", load_ready, 1'b0);
        wait_tick();
        check("mid_busy_at_tick", load_ready, 1'b0);
        @(negedge clk);
        check("mid_free_after_tick", load_ready, 1'b1);
        wait_lit(0, 8'h04);

        // Enable drop during digit 2.
        wait_lit(2, 8'h02);
        enable = 1'b0;
        @(negedge clk);
        check("drop_anode", anode_n, 4'b1111);
        check("drop_idx", digit_idx, 2'd0);
        check("drop_tick", frame_tick, 1'b0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("reen_dead0", anode_n, 4'b1111);
        @(negedge clk);
        check("reen_dead1", anode_n, 4'b1111);
        @(negedge clk);
        check("reen_lit_anode", anode_n, 4'b1110);
        check("reen_lit_code", digit_code_out, 8'h04);

        // Reset with a pending load.
        wait_lit(1, 8'h03);
        load(32'hAABBCCDD);
        check("prst_busy", load_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("prst_anode", anode_n, 4'b1111);
        check("prst_ready", load_ready, 1'b1);
        check("prst_code", digit_code_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick();
        check("prst_ready_after", load_ready, 1'b1);
`ifndef SEG7_LEADING_ZERO_BLANK_EN
        wait_lit(2, 8'h00);
`endif

        // Leading-zero data: lit-cycle count per frame depends on the build.
        load(32'h00000500);
        wait_tick();
        wait_tick();
        lit = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (anode_n !== 4'b1111) lit++;
        end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("lzb_lit_cycles", lit, 2 * PRE);
`else
        check("lzb_lit_cycles", lit, NUM * PRE);
`endif
        check("lzb_tick_end", frame_tick, 1'b1);
        wait_lit(1, 8'h05);
        wait_lit(0, 8'h00);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one segmentos_7 decoder.
- Drives the 8-bit digit code into the shared decoder input (data_segmentos_in) and sequences the active-low digit enables.
- Double-buffers the displayed values so updates take effect only at frame boundaries (no tearing).
- Inserts blanking dead time between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, range 2..8.
- PRESCALE, 50000: clock cycles each digit is lit per slot, must be >= 1.
- DEAD_CYCLES, 16: blanked cycles before each digit's lit period, may be 0.
- IDX_W, 2: width of digit_idx, equal to clog2(NUM_DIGITS).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- enable  in  1  scan enable. Low forces IDLE.
- data_in  in  8*NUM_DIGITS  packed digit codes. Digit 0 is bits [7:0].
- load_valid  in  1  update request for data_in.
- load_ready  out  1  shadow buffer free. Equals !pending.
- digit_code_out  out  8  code of the current digit, to the decoder input.
- anode_n  out  NUM_DIGITS  digit enables, active-low.
- digit_idx  out  IDX_W  index of the current digit slot.
- frame_tick  out  1  one-cycle pulse at frame wrap.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: anode_n all 1, digit_code_out 0, digit_idx 0, frame_tick 0, load_ready 1.
  - Internal state: active and shadow registers 0, pending 0, state IDLE, counters 0.
- Load handshake:
  - Accept occurs on a rising edge where load_valid && load_ready.
  - On accept: shadow <= data_in, pending <= 1.
  - No accept is possible while pending=1.
- Commit (active <= shadow, pending <= 0) happens:
  - on the frame-wrap cycle, or
  - on any cycle in IDLE while pending=1.
- digit_code_out = active[digit_idx] in the DEAD and ON states; 0 in IDLE.
- State machine (registered):
  - IDLE: anode_n all 1, digit_idx 0, counters 0.
    - enable=1 -> DEAD, or directly ON if DEAD_CYCLES=0.
  - DEAD: anode_n all 1.
    - After DEAD_CYCLES cycles -> ON.
  - ON: anode_n[digit_idx]=0, all other bits 1.
    - After PRESCALE cycles -> DEAD (or ON if DEAD_CYCLES=0) with digit_idx+1.
    - digit_idx wraps from NUM_DIGITS-1 to 0.
- Frame wrap:
  - Occurs on the last ON cycle of digit NUM_DIGITS-1.
  - frame_tick=1 for that cycle only, and commit occurs.
  - Digit 0 of the next frame shows the committed values.
- Timing:
  - Frame length = NUM_DIGITS*(PRESCALE+DEAD_CYCLES) cycles.
  - First lit cycle is DEAD_CYCLES+1 cycles after enable is sampled high in IDLE.
- enable deasserted in any state: next state IDLE, anode_n all 1 next cycle, digit_idx 0. There is no frame_tick.
- Re-enable always restarts at digit 0 with a full dead period.
- Counters are sized to PRESCALE and DEAD_CYCLES and never overflow.
- Reset mid-operation discards active, shadow and pending contents immediately.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - In the ON slot of digit i, anode_n stays all 1 when active[j]==8'h00 for every j>=i.
  - Digit 0 is never blanked.
  - Slot timing, digit_idx, digit_code_out and frame_tick are unchanged.
- Undefined: every digit is lit in its ON slot regardless of value.

Test Plan (NUM_DIGITS=4, PRESCALE=4, DEAD_CYCLES=2):
- Reset: rst_n=0 asynchronously mid-cycle -> anode_n=4'b1111, digit_code_out=8'h00, load_ready=1 immediately. Release with enable=0 -> outputs hold.
- Load in IDLE:
  - Stimulus: data_in=32'h09050100 with load_valid for 1 cycle, then enable=1.
  - Expect: load_ready low for 1 cycle, then 1.
  - Expect: 2 cycles anode 1111 / code 00, then 4 cycles anode 1110 / code 00.
  - Expect: 2 dead cycles, then 4 cycles anode 1101 / code 01, then codes 05 and 09.
  - Expect: frame_tick every 24 cycles.
- Mid-frame update:
  - Stimulus: load 32'h01020304 during digit 1.
  - Expect: load_ready=0 and the old codes until frame_tick.
  - Expect: next digit 0 shows 04, and load_ready=1 the cycle after frame_tick.
- Enable drop: enable=0 during digit 2 ON -> next cycle anode_n=1111, digit_idx=0, no frame_tick. Re-enable -> dead period, then digit 0.
- Reset with pending: assert rst_n=0 during ON with pending=1 -> anode_n=1111 at once. After release and enable=1 -> all codes 00, load_ready=1.
- Leading-zero blanking: with SEG7_LEADING_ZERO_BLANK_EN and data 32'h00000500 -> anode_n stays 1111 in the digit 3 and 2 slots; digit 1 lit with 05, digit 0 lit with 00. Without the macro, all four digits are lit.
